// File: rtl/perif_uart_pkg.sv
// perif_uart_pkg: state encoding, byte width and start-timeout default shared by the
// UART TX arbiter slice.
package perif_uart_pkg;

  localparam int C_BYTE_W        = 8;
  localparam int C_START_TIMEOUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_END
  } tx_arb_state_e;

  // Round-robin successor of requester idx among nb requesters.
  function automatic int rr_next(input int idx, input int nb);
    return (idx >= nb - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/perif_rr_arbiter.sv
// perif_rr_arbiter: purely combinational round-robin winner search.
// The search starts at i_ptr and wraps from P_NB_REQ-1 back to 0.
module perif_rr_arbiter #(
  parameter int P_NB_REQ = 2,
  parameter int P_PTR_W  = $clog2(P_NB_REQ)
) (
  input  logic [P_NB_REQ-1:0] i_req,
  input  logic [P_PTR_W-1:0]  i_ptr,
  output logic [P_NB_REQ-1:0] o_gnt
);

  always_comb begin
    logic w_found;
    int   w_idx;
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < P_NB_REQ; i++) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= P_NB_REQ) w_idx = w_idx - P_NB_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/perif_uart_tx_arbiter.sv
// perif_uart_tx_arbiter: round-robin sharing of one UART transmitter by P_NB_REQ byte sources.
// Define PERIF_UART_TX_ARB_LOCK_EN to add the per-requester lock input i_req_lock.
module perif_uart_tx_arbiter
  import perif_uart_pkg::*;
#(
  parameter int P_NB_REQ        = 2,
  parameter int P_START_TIMEOUT = C_START_TIMEOUT
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic [P_NB_REQ-1:0]          i_req_valid,
  input  logic [C_BYTE_W*P_NB_REQ-1:0] i_req_data,
  output logic [P_NB_REQ-1:0]          o_req_ready,
`ifdef PERIF_UART_TX_ARB_LOCK_EN
  input  logic [P_NB_REQ-1:0]          i_req_lock,
`endif
  output logic [P_NB_REQ-1:0]          o_grant,
  output logic                         o_wr_en,
  output logic [C_BYTE_W-1:0]          o_data_tx,
  input  logic                         i_tx_full,
  output logic                         o_err
);

  localparam int L_PTR_W = $clog2(P_NB_REQ);
  localparam int L_CNT_W = $clog2(P_START_TIMEOUT + 1);
  localparam logic [L_CNT_W-1:0] L_CNT_LAST = L_CNT_W'(P_START_TIMEOUT - 1);

  tx_arb_state_e        r_state, w_state_nxt;
  logic [P_NB_REQ-1:0]  r_grant, w_grant_nxt;
  logic [C_BYTE_W-1:0]  r_data, w_data_nxt;
  logic [L_PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [L_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_err, w_err_nxt;

  logic [P_NB_REQ-1:0]  w_arb_req;
  logic [P_NB_REQ-1:0]  w_win;
  logic [C_BYTE_W-1:0]  w_win_data;
  int                   w_win_idx;
  logic                 w_accept;

  perif_rr_arbiter #(
    .P_NB_REQ (P_NB_REQ),
    .P_PTR_W  (L_PTR_W)
  ) u_rr_arbiter (
    .i_req (w_arb_req),
    .i_ptr (r_ptr),
    .o_gnt (w_win)
  );

  // Reset gates acceptance so o_req_ready is low while reset is held.
  assign w_accept = (r_state == ST_IDLE) && i_en && !i_rst && (|w_win);

  always_comb begin
    w_win_data = '0;
    w_win_idx  = 0;
    for (int k = 0; k < P_NB_REQ; k++) begin
      if (w_win[k]) begin
        w_win_data = i_req_data[C_BYTE_W*k +: C_BYTE_W];
        w_win_idx  = k;
      end
    end
  end

`ifdef PERIF_UART_TX_ARB_LOCK_EN
  logic [P_NB_REQ-1:0] r_lock, w_lock_nxt;
  logic                w_lock_hold;

  // A held lock narrows arbitration to its owner, even when the owner has nothing to send.
  always_comb begin
    w_lock_hold = |(r_lock & i_req_lock);
    w_arb_req   = w_lock_hold ? (i_req_valid & r_lock) : i_req_valid;
    w_lock_nxt  = r_lock;
    if (!i_en) begin
      w_lock_nxt = '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept)          w_lock_nxt = w_win & i_req_lock;
      else if (!w_lock_hold) w_lock_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lock <= '0;
    else       r_lock <= w_lock_nxt;
  end
`else
  always_comb w_arb_req = i_req_valid;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_data_nxt  = r_data;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_grant_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = ST_ISSUE;
            w_grant_nxt = w_win;
            w_data_nxt  = w_win_data;
            w_ptr_nxt   = L_PTR_W'(rr_next(w_win_idx, P_NB_REQ));
            w_cnt_nxt   = '0;
          end
        end
        ST_ISSUE: begin
          w_state_nxt = ST_WAIT_START;
          w_cnt_nxt   = '0;
        end
        ST_WAIT_START: begin
          if (i_tx_full) begin
            w_state_nxt = ST_WAIT_END;
          end else if (r_cnt == L_CNT_LAST) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + L_CNT_W'(1);
          end
        end
        ST_WAIT_END: begin
          if (!i_tx_full) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_data  <= w_data_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_req_ready = w_accept ? w_win : '0;
  assign o_grant     = r_grant;
  assign o_wr_en     = (r_state == ST_ISSUE);
  assign o_data_tx   = r_data;
  assign o_err       = r_err;

endmodule

// File: tb/tb_perif_uart_tx_arbiter.sv
// tb_perif_uart_tx_arbiter: randomized frames against a transaction-level arbitration model,
// with a behavioural transmitter (3 cycles per bit) driving the busy flag.
module tb_perif_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int TO   = 4;
  localparam int BAUD = 3;
`ifdef PERIF_UART_TX_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   reqValid;
  logic [8*N-1:0] reqData;
  logic [N-1:0]   reqReady;
  logic [N-1:0]   reqLock;
  logic [N-1:0]   grant;
  logic           wrEn;
  logic [7:0]     dataTx;
  logic           txFull;
  logic           err;

  int checks = 0;
  int errors = 0;
  int mLast  = N - 1;
  int mOwner = -1;

  perif_uart_tx_arbiter #(
    .P_NB_REQ        (N),
    .P_START_TIMEOUT (TO)
  ) dut (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_en        (enable),
    .i_req_valid (reqValid),
    .i_req_data  (reqData),
    .o_req_ready (reqReady),
`ifdef PERIF_UART_TX_ARB_LOCK_EN
    .i_req_lock  (reqLock),
`endif
    .o_grant     (grant),
    .o_wr_en     (wrEn),
    .o_data_tx   (dataTx),
    .i_tx_full   (txFull),
    .o_err       (err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next owner: first eligible requester after the last accepted one, wrapping.
  function automatic int modelWinner(input logic [N-1:0] valid, input logic [N-1:0] lock);
    logic [N-1:0] elig;
    elig = valid;
    if (LOCK_EN && mOwner >= 0 && lock[mOwner]) elig = valid & (N'(1) << mOwner);
    for (int i = 0; i < N; i++) begin
      if (elig[(mLast + 1 + i) % N]) return (mLast + 1 + i) % N;
    end
    return 0;
  endfunction

  // mode 0: normal frame, 1: start timeout, 2: disable mid-frame, 3: reset in WAIT_START
  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] lock,
                               input logic [8*N-1:0] data, input int mode, input int dly);
    int           k;
    logic [7:0]   byteExp;
    logic [N-1:0] gExp;
    logic [9:0]   line;
    if (LOCK_EN && mOwner >= 0 && lock[mOwner]) valid[mOwner] = 1'b1;
    if (valid == '0) valid[0] = 1'b1;
    k       = modelWinner(valid, lock);
    byteExp = data[8*k +: 8];
    gExp    = N'(1) << k;
    line    = '0;

    enable = 1'b1; txFull = 1'b0;
    reqValid = valid; reqLock = lock; reqData = data;
    sample();
    checkOutput("ready_accept", 32'(reqReady), 32'(gExp));
    checkOutput("grant_idle", 32'(grant), 32'(0));
    checkOutput("wr_en_idle", 32'(wrEn), 32'(0));
    tick();
    mLast  = k;
    mOwner = (LOCK_EN && lock[k]) ? k : -1;

    reqValid = N'($urandom);
    sample();
    checkOutput("wr_en_issue", 32'(wrEn), 32'(1));
    checkOutput("grant_issue", 32'(grant), 32'(gExp));
    checkOutput("data_issue", 32'(dataTx), 32'(byteExp));
    checkOutput("ready_issue", 32'(reqReady), 32'(0));
    tick();

    if (mode == 0 || mode == 2) begin
      for (int c = 0; c < dly; c++) begin
        reqValid = N'($urandom);
        sample();
        checkOutput("wr_en_wait", 32'(wrEn), 32'(0));
        checkOutput("grant_wait", 32'(grant), 32'(gExp));
        checkOutput("ready_wait", 32'(reqReady), 32'(0));
        tick();
      end
      txFull = 1'b1;
      for (int c = 0; c < BAUD * 10; c++) begin
        reqValid = N'($urandom);
        if (mode == 2 && c == 10) break;
        sample();
        checkOutput("data_frame", 32'(dataTx), 32'(byteExp));
        checkOutput("ready_frame", 32'(reqReady), 32'(0));
        if (c % BAUD == 1) begin
          if (c / BAUD == 0)      line[0] = 1'b0;
          else if (c / BAUD == 9) line[9] = 1'b1;
          else                    line[c / BAUD] = dataTx[c / BAUD - 1];
        end
        tick();
      end
      if (mode == 2) begin
        enable = 1'b0;
        sample();
        checkOutput("ready_disabled", 32'(reqReady), 32'(0));
        checkOutput("grant_before_drop", 32'(grant), 32'(gExp));
        tick();
        mOwner = -1;
        sample();
        checkOutput("grant_dropped", 32'(grant), 32'(0));
        checkOutput("wr_en_dropped", 32'(wrEn), 32'(0));
        checkOutput("ready_still_off", 32'(reqReady), 32'(0));
        tick();
        txFull = 1'b0; enable = 1'b1; reqValid = '0;
        sample();
        checkOutput("grant_reenabled", 32'(grant), 32'(0));
        tick();
      end else begin
        checkOutput("serial_line", 32'(line), 32'({1'b1, byteExp, 1'b0}));
        txFull = 1'b0;
        sample();
        checkOutput("grant_last_busy", 32'(grant), 32'(gExp));
        checkOutput("ready_last_busy", 32'(reqReady), 32'(0));
        tick();
        reqValid = '0;
        sample();
        checkOutput("grant_released", 32'(grant), 32'(0));
        checkOutput("err_normal", 32'(err), 32'(0));
        tick();
      end
    end else begin
      for (int c = 1; c <= TO; c++) begin
        reqValid = N'($urandom);
        if (mode == 3 && c == 2) begin
          reset = 1'b1; reqValid = '1;
          #2;
          checkOutput("rst_ready", 32'(reqReady), 32'(0));
          checkOutput("rst_grant", 32'(grant), 32'(0));
          checkOutput("rst_wr_en", 32'(wrEn), 32'(0));
          checkOutput("rst_data", 32'(dataTx), 32'(0));
          checkOutput("rst_err", 32'(err), 32'(0));
          mLast = N - 1; mOwner = -1;
          @(posedge clock);
          #1;
          reset = 1'b0; reqValid = '0;
          return;
        end
        sample();
        checkOutput("err_early", 32'(err), 32'(0));
        checkOutput("grant_start_wait", 32'(grant), 32'(gExp));
        tick();
      end
      reqValid = '0;
      sample();
      checkOutput("err_timeout", 32'(err), 32'(1));
      checkOutput("grant_timeout", 32'(grant), 32'(0));
      tick();
      sample();
      checkOutput("err_one_cycle", 32'(err), 32'(0));
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; reqValid = '1; reqLock = '0;
    reqData = $urandom; txFull = 1'b0;
    #2;
    checkOutput("reset_ready", 32'(reqReady), 32'(0));
    checkOutput("reset_grant", 32'(grant), 32'(0));
    checkOutput("reset_wr_en", 32'(wrEn), 32'(0));
    checkOutput("reset_data", 32'(dataTx), 32'(0));
    checkOutput("reset_err", 32'(err), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b0; reqValid = '0;
    tick();

    $display("[TB] contention req0/req1");
    for (int i = 0; i < 3; i++) applyStimulus(4'b0011, '0, 32'h0000_2211, 0, 1);
    $display("[TB] single byte A5");
    applyStimulus(4'b0001, '0, 32'h0000_00A5, 0, 0);
    $display("[TB] start timeout");
    applyStimulus(N'($urandom), '0, $urandom, 1, 0);
    $display("[TB] disable mid-frame");
    applyStimulus(N'($urandom), '0, $urandom, 2, 2);
    applyStimulus(4'b1111, '0, $urandom, 0, 3);

    $display("[TB] randomized frames");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(N'($urandom_range(1, 15)), LOCK_EN ? N'($urandom) : '0,
                    $urandom, $urandom_range(0, 2), $urandom_range(0, TO - 1));
    end

`ifdef PERIF_UART_TX_ARB_LOCK_EN
    $display("[TB] lock held by req1");
    applyStimulus(4'b0001, '0, $urandom, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0011, 4'b0010, 32'h0000_2211, 0, 0);
    applyStimulus(4'b0011, '0, 32'h0000_2211, 0, 0);
`endif

    $display("[TB] reset during start wait");
    applyStimulus(4'b0100, '0, $urandom, 3, 0);
    applyStimulus(4'b1010, '0, $urandom, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perif_uart_tx_arbiter.md
PERIF_UART_TX_ARBITER -- requirements
Module: perif_uart_tx_arbiter

Interface
REQ-001 SHALL have parameter P_NB_REQ, default 2, number of byte requesters sharing one UART transmitter (range 2..8).
REQ-002 SHALL have parameter P_START_TIMEOUT, default 4, cycles allowed for the transmitter to report busy after a write.
REQ-003 SHALL have port i_clk  input  1  global clock; the block uses one clock only.
REQ-004 SHALL have port i_rst  input  1  global reset; asynchronous, active-high.
REQ-005 SHALL have port i_en  input  1  enable; mirrors the transmitter enable.
REQ-006 SHALL have port i_req_valid  input  P_NB_REQ  per-requester byte valid.
REQ-007 SHALL have port i_req_data  input  8*P_NB_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-008 SHALL have port o_req_ready  output  P_NB_REQ  per-requester accept, at most one bit high.
REQ-009 SHALL have port i_req_lock  input  P_NB_REQ  per-requester lock request (present only with the macro of REQ-026).
REQ-010 SHALL have port o_grant  output  P_NB_REQ  one-hot owner of the byte in flight, zero when idle.
REQ-011 SHALL have port o_wr_en  output  1  one-cycle write strobe to the transmitter.
REQ-012 SHALL have port o_data_tx  output  8  byte to the transmitter, held for the whole frame.
REQ-013 SHALL have port i_tx_full  input  1  transmitter busy (high from start bit to end of stop bit).
REQ-014 SHALL have port o_err  output  1  one-cycle pulse on start timeout.

Function
REQ-015 SHALL implement states ST_IDLE, ST_ISSUE, ST_WAIT_START, ST_WAIT_END.
REQ-016 ST_IDLE: when i_en=1 and any i_req_valid bit is high, SHALL raise o_req_ready combinationally for the round-robin winner only, capture its byte into o_data_tx, set o_grant, and go to ST_ISSUE.
REQ-017 Round-robin: search SHALL start at the requester after the last accepted one, with index P_NB_REQ-1 wrapping to 0; after reset the search starts at requester 0.
REQ-018 ST_ISSUE SHALL assert o_wr_en for exactly one cycle, then go to ST_WAIT_START (accept at cycle t gives o_wr_en at t+1).
REQ-019 ST_WAIT_START SHALL go to ST_WAIT_END when i_tx_full=1; after P_START_TIMEOUT cycles without i_tx_full it SHALL pulse o_err, clear o_grant and go to ST_IDLE.
REQ-020 ST_WAIT_END SHALL go to ST_IDLE on the first cycle i_tx_full=0, clearing o_grant; a new acceptance is possible on the following cycle.
REQ-021 o_data_tx SHALL stay unchanged from capture until the return to ST_IDLE, because the transmitter samples the data bits during the frame.
REQ-022 o_req_ready SHALL be zero in every state other than ST_IDLE and whenever i_en=0.
REQ-023 i_en=0 in any state SHALL force ST_IDLE on the next edge, clear o_grant and o_wr_en, and retain the round-robin pointer; the byte in flight is dropped.
REQ-024 Valid bits that drop before acceptance SHALL be ignored; requesters are not required to hold valid.

Reset
REQ-025 Asynchronous reset SHALL give: state ST_IDLE, o_req_ready=0, o_grant=0, o_wr_en=0, o_data_tx=8'h00, o_err=0, round-robin pointer=0, lock owner cleared.

Configuration
REQ-026 With macro PERIF_UART_TX_ARB_LOCK_EN defined: if i_req_lock[k] is high when requester k is accepted, then while i_req_lock[k] stays high, ST_IDLE SHALL grant only requester k, and other requesters wait even if k has no valid byte. The lock SHALL release on the first ST_IDLE cycle with i_req_lock[k]=0, and also on reset or i_en=0.
REQ-027 Without the macro, port i_req_lock SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-028 State enum and P_START_TIMEOUT default SHALL live in shared package perif_uart_pkg.
REQ-029 The winner search SHALL be a sub-module perif_rr_arbiter: request vector and pointer in, one-hot grant out, purely combinational.

Verification
REQ-030 Single requester: req0 sends 8'hA5 with the transmitter at baudrate 3 -> o_wr_en one cycle after accept, o_data_tx=8'hA5 stable until i_tx_full falls, serial line shows 0,10100101 LSB-first,1.
REQ-031 Contention: req0 and req1 valid together with bytes 8'h11 and 8'h22 -> accept order req0, req1, req0; no frames overlap.
REQ-032 Timeout: i_tx_full tied 0 -> o_err pulses 5 cycles after o_wr_en (P_START_TIMEOUT=4), then ST_IDLE.
REQ-033 Mid-frame disable: i_en dropped during ST_WAIT_END -> o_grant=0 next cycle, no o_req_ready until i_en=1; after re-enable the next grant follows the retained pointer.
REQ-034 Lock (macro on): req1 holds lock for 3 bytes while req0 is valid -> bytes from req1 go out 3 times in a row, then req0 is served.
REQ-035 Reset asserted asynchronously mid-ST_WAIT_START -> all outputs at their REQ-025 values before the next clock edge.
